acc_reg_bank: RTL and testbench
===============================

ACC_REG_BANK -- requirements
Module: acc_reg_bank

Interface
REQ-001 SHALL have parameter DATA_W, default 16, input sample width (signed two's complement).
REQ-002 SHALL have parameter ACC_W, default 24, accumulator width; ACC_W >= DATA_W.
REQ-003 SHALL have parameter N_CH, default 4, number of independent accumulator channels; N_CH >= 2; CH_W = max(1, clog2(N_CH)).
REQ-004 SHALL have parameter SAT_EN, default 1, 1 = saturate on overflow, 0 = wrap.
REQ-005 SHALL use one clock; reset is synchronous and active-low.
REQ-006 clk  in  1  clock, all state updates on rising edge.
REQ-007 rstn  in  1  synchronous active-low reset.
REQ-008 clr  in  1  clear all accumulators and overflow flags.
REQ-009 in_valid  in  1  input sample request.
REQ-010 in_ready  out  1  high when the block accepts samples (state IDLE).
REQ-011 in_ch  in  CH_W  target channel.
REQ-012 in_mode  in  2  00 load, 01 add, 10 subtract, 11 read/hold.
REQ-013 in_data  in  DATA_W  signed sample.
REQ-014 dump_req  in  1  start sequential readout of all channels.
REQ-015 dump_clr  in  1  sampled with dump_req; clear each channel as it is dumped.
REQ-016 out_valid  out  1  registered one-cycle result strobe.
REQ-017 out_ch  out  CH_W  channel of current result.
REQ-018 out_data  out  ACC_W  accumulator value of out_ch.
REQ-019 out_ovf  out  1  sticky overflow flag of out_ch.
REQ-020 dump_done  out  1  one-cycle pulse coincident with last dump beat.

Function
REQ-021 SHALL accept a sample at an edge where in_valid=1 and in_ready=1; transfer = handshake, no buffering.
REQ-022 SHALL sign-extend in_data to ACC_W; add/sub computed at ACC_W+1 bits.
REQ-023 Load: acc[in_ch] <= sext(in_data); ovf flag unchanged.
REQ-024 Add/sub overflow (result outside signed ACC_W range): SAT_EN=1 -> clamp to 2^(ACC_W-1)-1 or -2^(ACC_W-1); SAT_EN=0 -> keep low ACC_W bits; either case set ovf[in_ch]=1 (sticky until clr, dump_clr or reset).
REQ-025 Mode 11: no state change; still produces a result beat.
REQ-026 Latency: accepted at edge E -> out_valid=1 in cycle after E with out_ch=in_ch, out_data/out_ovf = post-update values; out_valid=0 otherwise.
REQ-027 Back-to-back samples to same channel SHALL chain with no stall (each uses previous update).
REQ-028 in_ch >= N_CH: sample accepted, no state change, no out_valid.
REQ-029 FSM states IDLE, DUMP; IDLE->DUMP on dump_req=1 (latch dump_clr, idx=0); DUMP->IDLE after beat idx=N_CH-1; dump_req in DUMP ignored.
REQ-030 In DUMP, one beat per edge: out_valid=1, out_ch=idx, out_data=acc[idx], out_ovf=ovf[idx]; if latched dump_clr, acc[idx], ovf[idx] <= 0 at same edge; idx increments.
REQ-031 in_ready=0 for exactly N_CH cycles per dump; in_valid ignored while in DUMP.
REQ-032 dump_req and accepted sample in same IDLE cycle: sample updates at that edge; dump beats start next edge and reflect the update.
REQ-033 Priority: rstn > clr > dump beat > sample.
REQ-034 clr=1: all acc and ovf <= 0, out_valid=0, dump_done=0; in DUMP, abort to IDLE with no dump_done.

Reset
REQ-035 rstn=0 at an edge: all acc, ovf, idx, out_valid, out_ch, out_data, out_ovf, dump_done <= 0; state <= IDLE (in_ready=1).
REQ-036 Reset mid-dump SHALL abort the dump with no further beats.

Verification (defaults DATA_W=16, ACC_W=24, N_CH=4)
REQ-037 Reset: rstn=0 one edge -> all outputs 0, in_ready=1; all channels read 0 via mode 11.
REQ-038 Load ch1 0x7FFF, then add ch1 0x7FFF next cycle -> beats 0x007FFF then 0x00FFFE, out_ovf=0.
REQ-039 Saturation: ch2 at 0x7FFF00, add 0x7FFF -> 0x7FFFFF, out_ovf=1; sub 0x0001 -> 0x7FFFFE, out_ovf still 1; SAT_EN=0 same stimulus -> 0x807EFF, out_ovf=1.
REQ-040 Chaining: add 0x0001 to ch3 on 3 consecutive cycles from 0 -> out_data 1, 2, 3 on consecutive cycles.
REQ-041 Dump: ch0..3 = 5,6,7,8, dump_req with dump_clr=1 -> beats ch0..3 = 5,6,7,8 on 4 consecutive cycles, dump_done on 4th, in_ready low 4 cycles; second dump -> all 0.
REQ-042 clr asserted during 2nd dump beat -> no further beats, no dump_done, all channels 0, in_ready=1 next cycle.

Source files
------------

// File: rtl/acc_reg_bank.sv
// Multi-channel signed accumulator bank with saturate/wrap arithmetic and a
// sequential dump engine that streams every channel out, optionally clearing it.
module acc_reg_bank #(
  parameter int DATA_W = 16,
  parameter int ACC_W  = 24,
  parameter int N_CH   = 4,
  parameter int SAT_EN = 1,
  localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              clr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CH_W-1:0]   in_ch,
  input  logic [1:0]        in_mode,
  input  logic [DATA_W-1:0] in_data,
  input  logic              dump_req,
  input  logic              dump_clr,
  output logic              out_valid,
  output logic [CH_W-1:0]   out_ch,
  output logic [ACC_W-1:0]  out_data,
  output logic              out_ovf,
  output logic              dump_done
);

  typedef enum logic {IDLE = 1'b0, DUMP = 1'b1} state_t;
  typedef enum logic [1:0] {M_LOAD = 2'b00, M_ADD = 2'b01, M_SUB = 2'b10, M_READ = 2'b11} mode_t;

  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  state_t            state;
  logic [CH_W-1:0]   idx;
  logic              clr_lat;
  logic [ACC_W-1:0]  acc [N_CH];
  logic [N_CH-1:0]   ovf;

  logic [ACC_W-1:0]  cur;
  logic              cur_ovf;
  logic [ACC_W-1:0]  sext;
  logic [ACC_W:0]    sum;
  logic              ovf_hit;
  logic [ACC_W-1:0]  nxt;
  logic              nxt_ovf;
  logic              ch_ok;

  assign in_ready = (state == IDLE);
  assign ch_ok    = ({1'b0, in_ch} < (CH_W+1)'(N_CH));

  // Next value for the addressed channel, computed one bit wider than the
  // accumulator so overflow shows up as disagreement of the top two bits.
  always_comb begin
    // NOTE: every output gets a default up front so no path leaves a latch.
    cur     = '0;
    cur_ovf = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      if (in_ch == CH_W'(i)) begin
        cur     = acc[i];
        cur_ovf = ovf[i];
      end
    end
    sext = ACC_W'(signed'(in_data));
    if (mode_t'(in_mode) == M_SUB)
      sum = (ACC_W+1)'(signed'(cur)) - (ACC_W+1)'(signed'(sext));
    else
      sum = (ACC_W+1)'(signed'(cur)) + (ACC_W+1)'(signed'(sext));
    ovf_hit = sum[ACC_W] ^ sum[ACC_W-1];
    nxt     = cur;
    nxt_ovf = cur_ovf;
    case (mode_t'(in_mode))
      M_LOAD: nxt = sext;
      M_ADD, M_SUB: begin
        if (ovf_hit) begin
          nxt     = (SAT_EN != 0) ? (sum[ACC_W] ? ACC_MIN : ACC_MAX) : sum[ACC_W-1:0];
          nxt_ovf = 1'b1;
        end else begin
          nxt = sum[ACC_W-1:0];
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    if (!rstn || clr) begin
      // NOTE: the accumulator array is reset explicitly because reads after
      // reset or clr must return zero; this costs reset fan-out, not RAM.
      for (int i = 0; i < N_CH; i++) acc[i] <= '0;
      ovf       <= '0;
      idx       <= '0;
      clr_lat   <= 1'b0;
      state     <= IDLE;
      out_valid <= 1'b0;
      dump_done <= 1'b0;
      if (!rstn) begin
        out_ch   <= '0;
        out_data <= '0;
        out_ovf  <= 1'b0;
      end
    end else if (state == DUMP) begin
      out_valid <= 1'b1;
      out_ch    <= idx;
      out_data  <= acc[idx];
      out_ovf   <= ovf[idx];
      if (clr_lat) begin
        acc[idx] <= '0;
        ovf[idx] <= 1'b0;
      end
      idx <= idx + 1'b1;
      if (idx == CH_W'(N_CH-1)) begin
        state     <= IDLE;
        dump_done <= 1'b1;
      end else begin
        dump_done <= 1'b0;
      end
    end else begin
      out_valid <= 1'b0;
      dump_done <= 1'b0;
      if (in_valid && ch_ok) begin
        acc[in_ch] <= nxt;
        ovf[in_ch] <= nxt_ovf;
        out_valid  <= 1'b1;
        out_ch     <= in_ch;
        out_data   <= nxt;
        out_ovf    <= nxt_ovf;
      end
      if (dump_req) begin
        state   <= DUMP;
        idx     <= '0;
        clr_lat <= dump_clr;
      end
    end
  end

endmodule

// File: tb/tb_acc_reg_bank.sv
// Directed bench for acc_reg_bank: a saturating and a wrapping instance share
// stimulus; expected values are hand-computed constants.
module tb_acc_reg_bank;

  logic        clk = 1'b0;
  logic        rstn, clr, in_valid, dump_req, dump_clr;
  logic [1:0]  in_ch, in_mode;
  logic [15:0] in_data;

  logic        in_ready, out_valid, out_ovf, dump_done;
  logic [1:0]  out_ch;
  logic [23:0] out_data;
  logic        w_in_ready, w_out_valid, w_out_ovf, w_dump_done;
  logic [1:0]  w_out_ch;
  logic [23:0] w_out_data;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  acc_reg_bank #(.DATA_W(16), .ACC_W(24), .N_CH(4), .SAT_EN(1)) dut (
    .clk(clk), .rstn(rstn), .clr(clr), .in_valid(in_valid), .in_ready(in_ready),
    .in_ch(in_ch), .in_mode(in_mode), .in_data(in_data), .dump_req(dump_req),
    .dump_clr(dump_clr), .out_valid(out_valid), .out_ch(out_ch), .out_data(out_data),
    .out_ovf(out_ovf), .dump_done(dump_done));

  acc_reg_bank #(.DATA_W(16), .ACC_W(24), .N_CH(4), .SAT_EN(0)) dut_w (
    .clk(clk), .rstn(rstn), .clr(clr), .in_valid(in_valid), .in_ready(w_in_ready),
    .in_ch(in_ch), .in_mode(in_mode), .in_data(in_data), .dump_req(dump_req),
    .dump_clr(dump_clr), .out_valid(w_out_valid), .out_ch(w_out_ch), .out_data(w_out_data),
    .out_ovf(w_out_ovf), .dump_done(w_dump_done));

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Drive inputs at the falling edge, then sample 1 ns after the rising edge.
  task automatic step(input logic v, input logic [1:0] ch, input logic [1:0] mode,
                      input logic [15:0] data, input logic dreq, input logic dclr, input logic c);
    @(negedge clk);
    in_valid = v; in_ch = ch; in_mode = mode; in_data = data;
    dump_req = dreq; dump_clr = dclr; clr = c;
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input string tag, input logic [1:0] ch, input logic [23:0] data, input logic ovf_exp);
    check({tag, ".valid"}, {31'd0, out_valid}, 32'd1);
    check({tag, ".ch"},    {30'd0, out_ch}, {30'd0, ch});
    check({tag, ".data"},  {8'd0, out_data}, {8'd0, data});
    check({tag, ".ovf"},   {31'd0, out_ovf}, {31'd0, ovf_exp});
  endtask

  initial begin
    rstn = 1'b0; clr = 1'b0; in_valid = 1'b0; in_ch = '0; in_mode = '0;
    in_data = '0; dump_req = 1'b0; dump_clr = 1'b0;
    @(posedge clk); #1;
    check("rst.valid", {31'd0, out_valid}, 32'd0);
    check("rst.ch",    {30'd0, out_ch}, 32'd0);
    check("rst.data",  {8'd0, out_data}, 32'd0);
    check("rst.ovf",   {31'd0, out_ovf}, 32'd0);
    check("rst.done",  {31'd0, dump_done}, 32'd0);
    check("rst.ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk); rstn = 1'b1;
    for (int c = 0; c < 4; c++) begin
      step(1'b1, 2'(c), 2'b11, 16'h1234, 1'b0, 1'b0, 1'b0);
      beat($sformatf("rd0.ch%0d", c), 2'(c), 24'h0, 1'b0);
    end

    // Load then add to ch1 on consecutive cycles.
    step(1'b1, 2'd1, 2'b00, 16'h7FFF, 1'b0, 1'b0, 1'b0);
    beat("load1", 2'd1, 24'h007FFF, 1'b0);
    step(1'b1, 2'd1, 2'b01, 16'h7FFF, 1'b0, 1'b0, 1'b0);
    beat("add1", 2'd1, 24'h00FFFE, 1'b0);

    // Bring ch2 to 0x7FFF00 with 256 adds of 0x7FFF, then overflow it.
    for (int k = 0; k < 256; k++) step(1'b1, 2'd2, 2'b01, 16'h7FFF, 1'b0, 1'b0, 1'b0);
    beat("ch2.pre", 2'd2, 24'h7FFF00, 1'b0);
    step(1'b1, 2'd2, 2'b01, 16'h7FFF, 1'b0, 1'b0, 1'b0);
    beat("sat.add", 2'd2, 24'h7FFFFF, 1'b1);
    check("wrap.add.data", {8'd0, w_out_data}, 32'h00807EFF);
    check("wrap.add.ovf",  {31'd0, w_out_ovf}, 32'd1);
    step(1'b1, 2'd2, 2'b10, 16'h0001, 1'b0, 1'b0, 1'b0);
    beat("sat.sub", 2'd2, 24'h7FFFFE, 1'b1);
    check("wrap.sub.data", {8'd0, w_out_data}, 32'h00807EFE);
    check("wrap.sub.ovf",  {31'd0, w_out_ovf}, 32'd1);

    // Chained adds to ch3.
    for (int k = 1; k <= 3; k++) begin
      step(1'b1, 2'd3, 2'b01, 16'h0001, 1'b0, 1'b0, 1'b0);
      beat($sformatf("chain%0d", k), 2'd3, 24'(k), 1'b0);
    end

    // Negative sample sign-extends; clr then empties everything.
    step(1'b1, 2'd0, 2'b00, 16'hFFFE, 1'b0, 1'b0, 1'b0);
    beat("neg.load", 2'd0, 24'hFFFFFE, 1'b0);
    step(1'b0, 2'd0, 2'b00, 16'h0, 1'b0, 1'b0, 1'b1);
    check("clr.valid", {31'd0, out_valid}, 32'd0);
    step(1'b1, 2'd2, 2'b11, 16'h0, 1'b0, 1'b0, 1'b0);
    beat("clr.rd2", 2'd2, 24'h0, 1'b0);

    for (int c = 0; c < 4; c++) begin
      step(1'b1, 2'(c), 2'b00, 16'(5 + c), 1'b0, 1'b0, 1'b0);
      beat($sformatf("ld%0d", c), 2'(c), 24'(5 + c), 1'b0);
    end

    // Dump with clear; in_valid during the dump must be ignored.
    step(1'b0, 2'd0, 2'b00, 16'h0, 1'b1, 1'b1, 1'b0);
    check("d1.req.valid", {31'd0, out_valid}, 32'd0);
    check("d1.req.ready", {31'd0, in_ready}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 2'd0, 2'b00, 16'd999, 1'b0, 1'b0, 1'b0);
      beat($sformatf("d1.b%0d", i), 2'(i), 24'(5 + i), 1'b0);
      check($sformatf("d1.b%0d.done", i), {31'd0, dump_done}, {31'd0, i == 3});
      check($sformatf("d1.b%0d.ready", i), {31'd0, in_ready}, {31'd0, i == 3});
    end
    step(1'b0, 2'd0, 2'b00, 16'h0, 1'b0, 1'b0, 1'b0);
    check("d1.post.valid", {31'd0, out_valid}, 32'd0);
    check("d1.post.done",  {31'd0, dump_done}, 32'd0);

    step(1'b0, 2'd0, 2'b00, 16'h0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 2'd0, 2'b00, 16'h0, 1'b0, 1'b0, 1'b0);
      beat($sformatf("d2.b%0d", i), 2'(i), 24'h0, 1'b0);
    end

    // Sample and dump_req in the same cycle: dump reflects the load.
    step(1'b1, 2'd0, 2'b00, 16'd9, 1'b1, 1'b0, 1'b0);
    beat("d3.smp", 2'd0, 24'd9, 1'b0);
    step(1'b0, 2'd0, 2'b00, 16'h0, 1'b0, 1'b0, 1'b0);
    beat("d3.b0", 2'd0, 24'd9, 1'b0);

    // Abort: clr on the second beat of a dump.
    for (int i = 1; i < 4; i++) step(1'b0, 2'd0, 2'b00, 16'h0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 2'd0, 2'b00, 16'h0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 2'd0, 2'b00, 16'h0, 1'b0, 1'b0, 1'b0);
    beat("d4.b0", 2'd0, 24'd9, 1'b0);
    step(1'b0, 2'd0, 2'b00, 16'h0, 1'b0, 1'b0, 1'b1);
    check("abort.valid", {31'd0, out_valid}, 32'd0);
    check("abort.done",  {31'd0, dump_done}, 32'd0);
    check("abort.ready", {31'd0, in_ready}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 2'd0, 2'b00, 16'h0, 1'b0, 1'b0, 1'b0);
      check($sformatf("abort.idle%0d", i), {31'd0, out_valid | dump_done}, 32'd0);
    end
    for (int c = 0; c < 4; c++) begin
      step(1'b1, 2'(c), 2'b11, 16'h0, 1'b0, 1'b0, 1'b0);
      beat($sformatf("abort.rd%0d", c), 2'(c), 24'h0, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
